// File: rtl/imem_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words, writes them
// to instruction memory from BASE_ADDR upward, then releases the core from reset.
module imem_loader #(
  parameter int unsigned BASE_ADDR = 1000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        reload,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [15:0] word_count,
  output logic        core_rst_n,
  output logic [31:0] start_pc,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [23:0] asm_q;
  logic        last_q;
  logic        accept_c;

  assign accept_c = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      asm_q      <= 24'd0;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= AW'(BASE_ADDR);
      mem_wdata  <= 32'd0;
      word_count <= 16'd0;
      core_rst_n <= 1'b0;
      start_pc   <= AW'(BASE_ADDR);
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_COLLECT;
          in_ready <= 1'b1;
        end

        S_COLLECT: begin
          if (accept_c) begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0:    asm_q[23:16] <= in_data;
              2'd1:    asm_q[15:8]  <= in_data;
              2'd2:    asm_q[7:0]   <= in_data;
              default: asm_q        <= asm_q;
            endcase
            // 4th byte completes the word; an early in_last drops the partial word
            if (idx == 2'd3) begin
              state     <= S_WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_wdata <= {asm_q, in_data};
              mem_addr  <= AW'(BASE_ADDR) + {14'd0, word_count, 2'b00};
              last_q    <= in_last;
            end else if (in_last) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              load_err <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          mem_we     <= 1'b0;
          word_count <= word_count + 16'd1;
          if (last_q) begin
            state      <= S_DONE;
            load_done  <= 1'b1;
            core_rst_n <= 1'b1;
          end else if (word_count == CW'(MAX_WORDS - 1)) begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end else begin
            state    <= S_COLLECT;
            in_ready <= 1'b1;
          end
        end

        S_DONE, S_ERR: begin
          if (reload) begin
            state      <= S_IDLE;
            word_count <= 16'd0;
            idx        <= 2'd0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            core_rst_n <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares every mem_we pulse.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // main instance (MAX_WORDS = 256)
  logic        in_valid, in_last, in_ready, reload;
  logic [7:0]  in_data;
  logic        mem_we, core_rst_n, load_done, load_err;
  logic [31:0] mem_addr, mem_wdata, start_pc;
  logic [15:0] word_count;

  // overflow instance (MAX_WORDS = 2)
  logic        ov_valid, ov_last, ov_ready, ov_reload;
  logic [7:0]  ov_data;
  logic        ov_we, ov_core_rst_n, ov_done, ov_err;
  logic [31:0] ov_addr, ov_wdata, ov_start_pc;
  logic [15:0] ov_count;

  int          checks = 0;
  int          fails  = 0;
  wr_t         exp_q[$];
  wr_t         exp_ov_q[$];
  int unsigned cyc = 0;
  int unsigned acc_q[$];

  imem_loader #(.BASE_ADDR(1000), .MAX_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .reload(reload), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .core_rst_n(core_rst_n), .start_pc(start_pc), .load_done(load_done),
    .load_err(load_err)
  );

  imem_loader #(.BASE_ADDR(1000), .MAX_WORDS(2)) dut_ov (
    .clk(clk), .rst_n(rst_n), .in_valid(ov_valid), .in_data(ov_data),
    .in_last(ov_last), .in_ready(ov_ready), .reload(ov_reload), .mem_we(ov_we),
    .mem_addr(ov_addr), .mem_wdata(ov_wdata), .word_count(ov_count),
    .core_rst_n(ov_core_rst_n), .start_pc(ov_start_pc), .load_done(ov_done),
    .load_err(ov_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst in_ready",   32'(in_ready),   32'd0);
    chk("rst mem_we",     32'(mem_we),     32'd0);
    chk("rst mem_wdata",  mem_wdata,       32'd0);
    chk("rst mem_addr",   mem_addr,        32'd1000);
    chk("rst start_pc",   start_pc,        32'd1000);
    chk("rst word_count", 32'(word_count), 32'd0);
    chk("rst core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst load_done",  32'(load_done),  32'd0);
    chk("rst load_err",   32'(load_err),   32'd0);
    chk("rst ov load_err", 32'(ov_err),    32'd0);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = b; in_last = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send wait for in_ready", 32'(in_ready), 32'd1);
    else @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (i == 2) repeat (3) @(negedge clk);
      end
      send(w[31 - 8*i -: 8], last && (i == 3));
    end
  endtask

  task automatic send_ov(input logic [7:0] b);
    int n = 0;
    ov_valid = 1'b1; ov_data = b; ov_last = 1'b0;
    while (!ov_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ov_ready) chk("ov send wait for in_ready", 32'(ov_ready), 32'd1);
    else @(negedge clk);
    ov_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // write monitors
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL extra write: addr 0x%08h data 0x%08h, none expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write addr", mem_addr, e.addr);
        chk("write data", mem_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && ov_we) begin
      if (exp_ov_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL ov extra write: addr 0x%08h data 0x%08h, none expected", ov_addr, ov_wdata);
      end else begin
        e = exp_ov_q.pop_front();
        chk("ov write addr", ov_addr, e.addr);
        chk("ov write data", ov_wdata, e.data);
      end
    end
  end

  // byte acceptance timestamps
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_q.push_back(cyc);
  end

  initial begin
    logic [31:0] words [3];
    words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'h99AABBCC;
    in_valid = 0; in_last = 0; in_data = 0; reload = 0;
    ov_valid = 0; ov_last = 0; ov_data = 0; ov_reload = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    chk("idle in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready after idle", 32'(in_ready), 32'd1);

    // overflow with MAX_WORDS = 2
    exp_ov_q.push_back('{32'd1000, 32'h01020304});
    exp_ov_q.push_back('{32'd1004, 32'h05060708});
    for (int i = 1; i <= 8; i++) send_ov(8'(i));
    @(negedge clk);
    ov_valid = 1'b1; ov_data = 8'h09;
    repeat (6) @(negedge clk);
    ov_valid = 1'b0;
    chk("ov load_err",   32'(ov_err),        32'd1);
    chk("ov load_done",  32'(ov_done),       32'd0);
    chk("ov core_rst_n", 32'(ov_core_rst_n), 32'd0);
    chk("ov word_count", 32'(ov_count),      32'd2);
    chk("ov in_ready",   32'(ov_ready),      32'd0);

    // single word program
    exp_q.push_back('{32'd1000, 32'h20110014});
    send(8'h20, 1'b0); send(8'h11, 1'b0); send(8'h00, 1'b0); send(8'h14, 1'b1);
    chk("done low during write", 32'(load_done), 32'd0);
    chk("core reset during write", 32'(core_rst_n), 32'd0);
    @(negedge clk);
    chk("done after write", 32'(load_done), 32'd1);
    chk("core released", 32'(core_rst_n), 32'd1);
    chk("word_count 1", 32'(word_count), 32'd1);
    chk("start_pc", start_pc, 32'd1000);
    chk("ready low in done", 32'(in_ready), 32'd0);

    // reload then 0xDEADBEEF
    pulse_reload();
    chk("reload clears done", 32'(load_done), 32'd0);
    chk("reload core reset", 32'(core_rst_n), 32'd0);
    chk("reload word_count", 32'(word_count), 32'd0);
    exp_q.push_back('{32'd1000, 32'hDEADBEEF});
    send_word(32'hDEADBEEF, 1'b1, 1'b0);
    @(negedge clk);
    chk("deadbeef done", 32'(load_done), 32'd1);

    // three words back-to-back
    pulse_reload();
    acc_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('{32'd1000 + 32'(4*i), words[i]});
    for (int i = 0; i < 3; i++) send_word(words[i], i == 2, 1'b0);
    @(negedge clk);
    chk("b2b word_count", 32'(word_count), 32'd3);
    chk("b2b done", 32'(load_done), 32'd1);
    chk("b2b accepted bytes", 32'(acc_q.size()), 32'd12);
    if (acc_q.size() == 12) begin
      chk("b2b bytes 1-4 span", 32'(acc_q[3] - acc_q[0]), 32'd3);
      chk("b2b ready gap word 1", 32'(acc_q[4] - acc_q[3]), 32'd2);
      chk("b2b ready gap word 2", 32'(acc_q[8] - acc_q[7]), 32'd2);
      chk("b2b 12 bytes cycles", 32'(acc_q[11] - acc_q[0] + 2), 32'd15);
    end

    // same words with random stalls
    pulse_reload();
    for (int i = 0; i < 3; i++) exp_q.push_back('{32'd1000 + 32'(4*i), words[i]});
    for (int i = 0; i < 3; i++) send_word(words[i], i == 2, 1'b1);
    @(negedge clk);
    chk("gap word_count", 32'(word_count), 32'd3);
    chk("gap done", 32'(load_done), 32'd1);

    // in_last on 2nd byte of word 1
    pulse_reload();
    exp_q.push_back('{32'd1000, 32'hCAFEF00D});
    send_word(32'hCAFEF00D, 1'b0, 1'b0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    repeat (4) @(negedge clk);
    chk("early last err", 32'(load_err), 32'd1);
    chk("early last done", 32'(load_done), 32'd0);
    chk("early last core reset", 32'(core_rst_n), 32'd0);
    chk("early last word_count", 32'(word_count), 32'd1);

    // async reset mid-word
    pulse_reload();
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("pending writes", 32'(exp_q.size()), 32'd0);
    chk("ov pending writes", 32'(exp_ov_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory before the pipelined core starts. It accepts a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit words. It writes the words to consecutive word addresses starting at the boot PC, then releases the core from reset. It is the write-side counterpart to the bench observers that read back PC, ALU and register-file state after execution, and it sits between the external load port and the instruction-memory write port inside `Top`.

## Interface
- `BASE_ADDR`, 1000: byte address of the first instruction word; also driven on `start_pc`.
- `MAX_WORDS`, 256: capacity in words; must be ≥1 and ≤65535.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  program byte.
- `in_last`  in  1  marks the final byte of the program; qualified by `in_valid`.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `reload`  in  1  restart a load from DONE or ERR.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  32  byte address of the word being written.
- `mem_wdata`  out  32  word being written.
- `word_count`  out  16  number of words written so far.
- `core_rst_n`  out  1  active-low reset to the core; low until the load completes.
- `start_pc`  out  32  boot PC for the core; constant `BASE_ADDR`.
- `load_done`  out  1  load finished cleanly; sticky.
- `load_err`  out  1  load aborted; sticky.

## Operation
- All outputs are registered.
- Reset values:
  - `in_ready`=0, `mem_we`=0, `mem_wdata`=0
  - `mem_addr`=`BASE_ADDR`, `start_pc`=`BASE_ADDR`
  - `word_count`=0, `core_rst_n`=0, `load_done`=0, `load_err`=0
  - state IDLE, byte index 0
- States:
  - IDLE: `in_ready`=0; moves to COLLECT unconditionally on the next edge.
  - COLLECT: `in_ready`=1. Each handshake (`in_valid`&&`in_ready`) stores the byte into lane 3−idx of the assembly register (first byte → [31:24]) and increments idx modulo 4.
    - On the 4th byte → WRITE.
    - If `in_last` is set on byte idx 0..2 → ERR; the partial word is not written.
  - WRITE: lasts exactly one cycle with `in_ready`=0.
    - `mem_we`=1, `mem_wdata`=assembled word, `mem_addr`=`BASE_ADDR`+4×`word_count` (32-bit wrap-around arithmetic).
    - `word_count` increments on the edge that leaves WRITE.
    - Next state:
      - DONE if the 4th byte carried `in_last`.
      - ERR if the word just written was word `MAX_WORDS`−1 without `in_last` (overflow).
      - COLLECT otherwise.
  - DONE: `load_done`=1, `core_rst_n`=1, `in_ready`=0. Input bytes are ignored.
  - ERR: `load_err`=1, `core_rst_n` held 0, `in_ready`=0.
- `reload`:
  - Sampled only in DONE or ERR; ignored in all other states.
  - Moves to IDLE with `word_count`=0, idx=0, `load_done`=`load_err`=0 and `core_rst_n`=0, all on the same edge.
  - Memory contents are not cleared.
- `mem_addr` holds the last written address when `mem_we`=0. Consumers qualify only on `mem_we`.
- `load_done` and `load_err` are never high together.

## Timing
- First `in_ready`=1 appears in the second cycle after `rst_n` deasserts (IDLE lasts one cycle).
- Latency from 4th-byte acceptance at edge N to `mem_we`=1 is the cycle N→N+1. COLLECT resumes at edge N+1, so peak throughput is 4 bytes per 5 cycles.
- Last word written at edge N: `load_done` and `core_rst_n` rise at edge N+1, with `word_count` final at that edge.
- `in_valid` may drop mid-word. Idx and the partial word are held indefinitely with no timeout.
- Asynchronous reset mid-load returns every output to its reset value immediately.
  - A `mem_we` pulse in progress is cut.
  - The partial word is discarded.
  - `core_rst_n` is forced to 0 at once.
- `in_last` without `in_valid` has no effect.

## Test plan
- Reset, then stream bytes 0x20,0x11,0x00,0x14 with `in_last` on the 4th byte:
  - one `mem_we` with addr 1000 and data 0x20110014
  - `word_count`=1; `load_done`=1 and `core_rst_n`=1 one edge after the write
  - `start_pc`=1000
- Three words streamed back-to-back with `in_valid` held high:
  - writes land at addresses 1000, 1004, 1008
  - `in_ready` is low exactly one cycle after each 4th byte
  - 12 bytes take 15 cycles
- Random `in_valid` gaps (including stalls between bytes 2 and 3):
  - words are identical to the gap-free run
  - no extra `mem_we` pulses
- `in_last` on the 2nd byte of word 1 → `load_err`=1, `core_rst_n`=0, `word_count`=1, and no second write.
- Overflow: `MAX_WORDS`=2 with 3 words sent → `load_err`=1 after the write at addr 1004; the third word is never written.
- From DONE, pulse `reload` then load one word 0xDEADBEEF:
  - `load_done` clears and `core_rst_n` drops the edge after the pulse
  - the write goes to addr 1000
  - `rst_n` pulsed mid-word afterwards returns all outputs to their reset values immediately
